// File: rtl/ir_queue_if.sv
// rtl/ir_queue_if.sv - handshake bundle between code-memory fetch and decode for ir_queue
interface ir_queue_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             w;
    logic [WIDTH-1:0] ir_in;
    logic             rd;
    logic             flush;
    logic [WIDTH-1:0] ir_out;
    logic             valid;
    logic             full;
    logic [CW-1:0]    count;

    modport master (
        output w, ir_in, rd, flush,
        input  ir_out, valid, full, count
    );

    modport slave (
        input  w, ir_in, rd, flush,
        output ir_out, valid, full, count
    );
endinterface

// File: rtl/ir_queue.sv
// rtl/ir_queue.sv - instruction register FIFO; head word is the current instruction, flush empties it
module ir_queue #(
    parameter int             WIDTH = 16,
    parameter int             DEPTH = 4,
    parameter logic [WIDTH-1:0] NOP = '0
) (
    input  logic       clk,
    input  logic       reset,
    ir_queue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [CW-1:0]    count_q;
    logic             valid_q;
    logic             full_q;
    logic             push;
    logic             pop;

    assign valid_q = (count_q != '0);
    assign full_q  = (count_q == CW'(DEPTH));

    // A pop frees the slot in the same edge, so a full queue still accepts w with rd.
    assign push = bus.w & (~full_q | bus.rd);
    assign pop  = bus.rd & valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wp      <= '0;
            rp      <= '0;
            count_q <= '0;
        end else if (flush_active()) begin
            rp      <= wp;
            count_q <= '0;
        end else begin
            if (push) begin
                wp <= wp + AW'(1);
            end
            if (pop) begin
                rp <= rp + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !bus.flush && push) begin
            mem[wp] <= bus.ir_in;
        end
    end

    function automatic logic flush_active();
        return bus.flush;
    endfunction

    assign bus.ir_out = valid_q ? mem[rp] : NOP;
    assign bus.valid  = valid_q;
    assign bus.full   = full_q;
    assign bus.count  = count_q;
endmodule
